dma_xfer_ctrl: RTL and testbench
================================

// Module: dma_xfer_ctrl
// PURPOSE
//  Transfer engine of the DMA, between the DMA AXI write-slave (register port) and the DMA AXI master.
//  Decodes CPU register writes (DMAEN/DMASRC/DMADST/DMALEN) and splits a DMALEN-word copy into bursts of up to 16 beats.
//  Each burst is a master read into a local 16-word buffer, then a master write from that buffer.
//  Raises interrupt_dma when the copy completes.
// PARAMETERS
//  DATA_W    32  data/address width
//  MAX_BURST 16  max beats per burst; also buffer depth
//  OFS_EN    12'h100 / OFS_SRC 12'h200 / OFS_DST 12'h300 / OFS_LEN 12'h400  register offsets, decoded on s_addr[11:0]
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous reset, active-high
//  s_addr         in   32  slave write address
//  s_data         in   32  slave write data
//  s_en           in   1   slave write beat (WVALID&&WREADY on DMA slave)
//  r_valid        in   1   master read beat handshake (RVALID&&RREADY)
//  w_valid        in   1   master write beat handshake (WVALID&&WREADY)
//  readData       in   32  master read data, valid when r_valid
//  addr           out  32  burst start address to master
//  bweb           out  4   byte write enable, active-low
//  write_data     out  32  write data for current write beat
//  burst_len      out  4   beats-1 of current burst
//  CEB            out  1   request strobe to master, active-low
//  WEB            out  1   0 = write burst, 1 = read burst
//  interrupt_dma  out  1   transfer-done interrupt, level
// BEHAVIOUR
//  Reset (sync): state IDLE; en/src/dst/len regs 0; CEB=1, WEB=1, bweb=4'hF, addr=0, burst_len=0, interrupt_dma=0.
//  Register write on s_en, offset match: SRC/DST store s_data with [1:0] forced 0; LEN stores 16-bit word count; EN stores s_data[0].
//  SRC/DST/LEN writes in any state other than IDLE/DONE are ignored.
//  Non-matching offsets are ignored.
//  FSM:
//   IDLE: EN write of 1 -> LOAD.
//   LOAD: beats = min(rem, MAX_BURST).
//     rem==0 -> DONE.
//     Otherwise -> RD_REQ.
//   RD_REQ: CEB=0, WEB=1, bweb=4'hF, addr=src, burst_len=beats-1, for exactly 1 cycle -> RD_DATA.
//   RD_DATA: each r_valid writes readData to buf[rptr++].
//     After beats handshakes -> WR_REQ. rptr resets to 0.
//   WR_REQ: CEB=0, WEB=0, bweb=4'h0, addr=dst, burst_len=beats-1, for 1 cycle -> WR_DATA.
//   WR_DATA: write_data = buf[wptr] combinationally; each w_valid increments wptr.
//     After beats handshakes -> NEXT.
//   NEXT: src += 4*beats, dst += 4*beats (mod 2^32), rem -= beats -> LOAD.
//   DONE: interrupt_dma=1 (registered, asserts the cycle after entering DONE).
//     EN write of 0 -> IDLE; interrupt_dma drops the next cycle.
//     EN write of 1 -> LOAD with current regs; a fresh LEN must be written first, else rem==0 gives immediate DONE.
//  rem is loaded from LEN on the IDLE/DONE->LOAD transition.
//  Bursts may cross 4 KB boundaries; no splitting.
//  Outside RD_REQ/WR_REQ: CEB=1; addr/burst_len/WEB hold their last values.
//  s_en is independent of master beats: a simultaneous s_en and r_valid/w_valid are both processed in the same cycle.
//  r_valid outside RD_DATA and w_valid outside WR_DATA are ignored.
//  Extra beats are never counted past beats.
//  Sync reset mid-burst: abandon immediately, return to reset values; buffer contents are don't-care.
// CONFIGURATION
//  DMA_ABORT_EN defined:
//   An EN write of 0 in RD_DATA/WR_DATA sets an abort flag.
//   The current burst completes; then -> DONE instead of NEXT/LOAD, with interrupt_dma=1.
//   An EN write of 0 in LOAD/RD_REQ/WR_REQ -> DONE at the next burst boundary.
//  DMA_ABORT_EN undefined:
//   EN writes outside IDLE/DONE are ignored; the transfer always runs to rem==0.
// TESTING
//  1. SRC=0x1000, DST=0x2000, LEN=4, EN=1 -> one read and one write burst.
//     Expect burst_len=3; 4 words copied in order; interrupt_dma=1; EN=0 clears it.
//  2. LEN=20 -> bursts of 16 then 4 beats.
//     Second read addr=SRC+0x40, second write addr=DST+0x40, burst_len=15 then 3.
//  3. LEN=0, EN=1 -> no CEB pulse; interrupt_dma=1 within 3 cycles.
//  4. Write SRC=0x5000 during RD_DATA -> ignored; later bursts still use the original SRC progression.
//     Inject r_valid and s_en in the same cycle -> both take effect.
//  5. Assert rst mid-WR_DATA -> next cycle all outputs at reset values.
//     A new EN=1 copies correctly from scratch.
//  6. DMA_ABORT_EN defined: LEN=40, EN=0 during burst 1 read -> burst 1 write still completes.
//     No third CEB pulse; interrupt_dma=1.
//     DMA_ABORT_EN undefined: the same stimulus gives all 3 bursts.

Source files
------------

// File: rtl/dma_xfer_ctrl.sv
// DMA transfer engine: decodes DMAEN/DMASRC/DMADST/DMALEN register writes
// and copies DMALEN words as read-then-write bursts of up to MAX_BURST beats.
// Optional macro: DMA_ABORT_EN (EN=0 while busy ends the copy at the next
// burst boundary); when undefined, busy-state EN writes are ignored.
// Ports: clk, rst (sync, active-high); s_addr/s_data/s_en register port;
//   r_valid/readData and w_valid master beat handshakes;
//   addr/bweb/write_data/burst_len/CEB/WEB master request; interrupt_dma.
module dma_xfer_ctrl #(
  parameter int          DATA_W    = 32,
  parameter int          MAX_BURST = 16,
  parameter logic [11:0] OFS_EN    = 12'h100,
  parameter logic [11:0] OFS_SRC   = 12'h200,
  parameter logic [11:0] OFS_DST   = 12'h300,
  parameter logic [11:0] OFS_LEN   = 12'h400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_en,
  input  logic              r_valid,
  input  logic              w_valid,
  input  logic [DATA_W-1:0] readData,
  output logic [DATA_W-1:0] addr,
  output logic [3:0]        bweb,
  output logic [DATA_W-1:0] write_data,
  output logic [3:0]        burst_len,
  output logic              CEB,
  output logic              WEB,
  output logic              interrupt_dma
);

  localparam int PW = $clog2(MAX_BURST);
  localparam int BW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD_REQ, S_RD_DATA,
    S_WR_REQ, S_WR_DATA, S_NEXT, S_DONE
  } state_t;

  state_t r_state, w_nxt;

  logic              r_en;
  logic [DATA_W-1:0] r_src, r_dst;
  logic [15:0]       r_len, r_rem;
  logic [BW-1:0]     r_beats, r_ptr;
  logic              r_abort;
  logic [DATA_W-1:0] r_addr;
  logic [3:0]        r_bweb, r_burst_len;
  logic              r_web, r_irq;
  logic [DATA_W-1:0] r_buf [MAX_BURST];

  logic          w_cfg, w_busy;
  logic          w_en_wr, w_src_wr, w_dst_wr, w_len_wr;
  logic          w_abort_set, w_last;
  logic [BW-1:0] w_beats;
  logic [DATA_W-1:0] w_step;
  logic          w_unused;

  assign w_cfg    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_busy   = !w_cfg;
  assign w_en_wr  = s_en && (s_addr[11:0] == OFS_EN);
  assign w_src_wr = s_en && (s_addr[11:0] == OFS_SRC) && w_cfg;
  assign w_dst_wr = s_en && (s_addr[11:0] == OFS_DST) && w_cfg;
  assign w_len_wr = s_en && (s_addr[11:0] == OFS_LEN) && w_cfg;

`ifdef DMA_ABORT_EN
  assign w_abort_set = w_en_wr && !s_data[0] && w_busy;
`else
  assign w_abort_set = 1'b0;
`endif

  assign w_beats = (r_rem >= 16'(MAX_BURST)) ? BW'(MAX_BURST)
                                             : r_rem[BW-1:0];
  assign w_last  = (r_ptr == r_beats - BW'(1));
  assign w_step  = DATA_W'({r_beats, 2'b00});

  assign w_unused = ^{s_addr[DATA_W-1:12], s_data[DATA_W-1:16], r_en};

  assign addr          = r_addr;
  assign bweb          = r_bweb;
  assign burst_len     = r_burst_len;
  assign WEB           = r_web;
  assign interrupt_dma = r_irq;
  assign CEB           = !((r_state == S_RD_REQ) ||
                           (r_state == S_WR_REQ));
  assign write_data    = r_buf[r_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_en_wr && s_data[0]) w_nxt = S_LOAD;
      S_LOAD:    if (r_abort || r_rem == 16'd0) w_nxt = S_DONE;
                 else w_nxt = S_RD_REQ;
      S_RD_REQ:  w_nxt = S_RD_DATA;
      S_RD_DATA: if (r_valid && w_last) w_nxt = S_WR_REQ;
      S_WR_REQ:  w_nxt = S_WR_DATA;
      S_WR_DATA: if (w_valid && w_last)
                   w_nxt = (r_abort || w_abort_set) ? S_DONE : S_NEXT;
      S_NEXT:    w_nxt = S_LOAD;
      S_DONE:    if (w_en_wr) w_nxt = s_data[0] ? S_LOAD : S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == S_RD_DATA && r_valid)
      r_buf[r_ptr[PW-1:0]] <= readData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en        <= 1'b0;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_rem       <= '0;
      r_beats     <= '0;
      r_ptr       <= '0;
      r_abort     <= 1'b0;
      r_addr      <= '0;
      r_bweb      <= 4'hF;
      r_burst_len <= '0;
      r_web       <= 1'b1;
      r_irq       <= 1'b0;
    end else begin
      r_irq <= (w_nxt == S_DONE);
      if (w_src_wr) r_src <= {s_data[DATA_W-1:2], 2'b00};
      if (w_dst_wr) r_dst <= {s_data[DATA_W-1:2], 2'b00};
      if (w_len_wr) r_len <= s_data[15:0];
      if (w_en_wr && (w_cfg || w_abort_set)) r_en <= s_data[0];
      if (w_abort_set) r_abort <= 1'b1;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          // LEN is consumed on start, so a re-enable needs a fresh LEN.
          if (w_nxt == S_LOAD) begin
            r_rem   <= r_len;
            r_len   <= '0;
            r_abort <= 1'b0;
          end
        end
        S_LOAD: begin
          r_beats <= w_beats;
          if (w_nxt == S_RD_REQ) begin
            r_addr      <= r_src;
            r_burst_len <= 4'(w_beats - BW'(1));
            r_web       <= 1'b1;
            r_bweb      <= 4'hF;
          end
        end
        S_RD_DATA: begin
          if (r_valid) begin
            r_ptr <= w_last ? '0 : r_ptr + BW'(1);
            if (w_last) begin
              r_addr <= r_dst;
              r_web  <= 1'b0;
              r_bweb <= 4'h0;
            end
          end
        end
        S_WR_DATA: begin
          if (w_valid) r_ptr <= w_last ? '0 : r_ptr + BW'(1);
        end
        S_NEXT: begin
          r_src <= r_src + w_step;
          r_dst <= r_dst + w_step;
          r_rem <= r_rem - 16'(r_beats);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed bench for dma_xfer_ctrl: acts as CPU register writer and as a
// bus master returning pat(addr) on reads and checking copied write data.
module tb_dma_xfer_ctrl;

  localparam logic [11:0] EN  = 12'h100;
  localparam logic [11:0] SRC = 12'h200;
  localparam logic [11:0] DST = 12'h300;
  localparam logic [11:0] LEN = 12'h400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_addr = '0, s_data = '0, readData = '0;
  logic        s_en = 1'b0, r_valid = 1'b0, w_valid = 1'b0;
  logic [31:0] addr, write_data;
  logic [3:0]  bweb, burst_len;
  logic        CEB, WEB, interrupt_dma;

  int n_chk = 0;
  int n_pass = 0;

  dma_xfer_ctrl dut (
    .clk(clk), .rst(rst),
    .s_addr(s_addr), .s_data(s_data), .s_en(s_en),
    .r_valid(r_valid), .w_valid(w_valid), .readData(readData),
    .addr(addr), .bweb(bweb), .write_data(write_data),
    .burst_len(burst_len), .CEB(CEB), .WEB(WEB),
    .interrupt_dma(interrupt_dma)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic reg_wr(logic [11:0] off, logic [31:0] d);
    @(negedge clk);
    s_addr = {20'h0, off};
    s_data = d;
    s_en   = 1'b1;
    @(negedge clk);
    s_en   = 1'b0;
    s_addr = '0;
  endtask

  task automatic wait_req(string tag, logic web, logic [31:0] a,
                          logic [3:0] bl);
    bit hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (CEB === 1'b0) hit = 1;
      else @(negedge clk);
    end
    chk({tag, "_req"}, 32'(hit), 32'd1);
    if (hit) begin
      chk({tag, "_web"}, 32'(WEB), 32'(web));
      chk({tag, "_addr"}, addr, a);
      chk({tag, "_blen"}, 32'(burst_len), 32'(bl));
      chk({tag, "_bweb"}, 32'(bweb), web ? 32'hF : 32'h0);
    end
  endtask

  task automatic do_rd(string tag, logic [31:0] src, int n, int inj_k,
                       logic [11:0] inj_off, logic [31:0] inj_d);
    wait_req({tag, "_rd"}, 1'b1, src, 4'(n - 1));
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      r_valid  = 1'b1;
      readData = pat(src + 32'(4 * k));
      if (k == inj_k) begin
        s_addr = {20'h0, inj_off};
        s_data = inj_d;
        s_en   = 1'b1;
      end
      @(negedge clk);
      s_en = 1'b0;
    end
    r_valid = 1'b0;
  endtask

  task automatic do_wr(string tag, logic [31:0] src, logic [31:0] dst,
                       int n, int stop);
    wait_req({tag, "_wr"}, 1'b0, dst, 4'(n - 1));
    @(negedge clk);
    for (int k = 0; k < stop; k++) begin
      chk({tag, "_wdata"}, write_data, pat(src + 32'(4 * k)));
      w_valid = 1'b1;
      @(negedge clk);
    end
    w_valid = 1'b0;
  endtask

  task automatic wait_irq(string tag, int bound);
    int pulses = 0;
    bit hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      if (CEB === 1'b0) pulses++;
      if (interrupt_dma === 1'b1) hit = 1;
    end
    chk({tag, "_irq"}, 32'(hit), 32'd1);
    chk({tag, "_noreq"}, 32'(pulses), 32'd0);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_ceb"}, 32'(CEB), 32'd1);
    chk({tag, "_web"}, 32'(WEB), 32'd1);
    chk({tag, "_bweb"}, 32'(bweb), 32'hF);
    chk({tag, "_addr"}, addr, 32'd0);
    chk({tag, "_blen"}, 32'(burst_len), 32'd0);
    chk({tag, "_irq"}, 32'(interrupt_dma), 32'd0);
  endtask

  task automatic start(logic [31:0] s, logic [31:0] d, logic [31:0] l);
    reg_wr(SRC, s);
    reg_wr(DST, d);
    reg_wr(LEN, l);
    reg_wr(EN, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;

    // 1: four words, low address bits of SRC/DST dropped
    start(32'h1003, 32'h2002, 32'd4);
    do_rd("t1", 32'h1000, 4, -1, 12'h0, 32'h0);
    do_wr("t1", 32'h1000, 32'h2000, 4, 4);
    wait_irq("t1", 5);
    reg_wr(EN, 32'd0);
    chk("t1_irq_clr", 32'(interrupt_dma), 32'd0);

    // 2: 20 words -> 16 + 4
    start(32'h3000, 32'h4000, 32'd20);
    do_rd("t2a", 32'h3000, 16, -1, 12'h0, 32'h0);
    do_wr("t2a", 32'h3000, 32'h4000, 16, 16);
    do_rd("t2b", 32'h3040, 4, -1, 12'h0, 32'h0);
    do_wr("t2b", 32'h3040, 32'h4040, 4, 4);
    wait_irq("t2", 5);
    reg_wr(EN, 32'd0);

    // 3: zero length, then re-enable without fresh LEN
    reg_wr(LEN, 32'd0);
    reg_wr(EN, 32'd1);
    wait_irq("t3", 3);
    reg_wr(EN, 32'd1);
    wait_irq("t3b", 3);
    reg_wr(EN, 32'd0);

    // 4: SRC write during read, same cycle as a read beat
    start(32'h6000, 32'h7000, 32'd20);
    do_rd("t4a", 32'h6000, 16, 2, SRC, 32'h5000);
    do_wr("t4a", 32'h6000, 32'h7000, 16, 16);
    do_rd("t4b", 32'h6040, 4, -1, 12'h0, 32'h0);
    do_wr("t4b", 32'h6040, 32'h7040, 4, 4);
    wait_irq("t4", 5);
    reg_wr(EN, 32'd0);

    // 5: reset in the middle of a write burst, then a clean copy
    start(32'h8000, 32'h9000, 32'd8);
    do_rd("t5", 32'h8000, 8, -1, 12'h0, 32'h0);
    do_wr("t5", 32'h8000, 32'h9000, 8, 3);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("t5rst");
    rst = 1'b0;
    start(32'hA000, 32'hB000, 32'd8);
    do_rd("t5n", 32'hA000, 8, -1, 12'h0, 32'h0);
    do_wr("t5n", 32'hA000, 32'hB000, 8, 8);
    wait_irq("t5n", 5);
    reg_wr(EN, 32'd0);

    // 6: EN=0 during the first read burst of a 40-word copy
    start(32'hC000, 32'hD000, 32'd40);
    do_rd("t6a", 32'hC000, 16, 5, EN, 32'd0);
    do_wr("t6a", 32'hC000, 32'hD000, 16, 16);
`ifdef DMA_ABORT_EN
    wait_irq("t6", 6);
`else
    do_rd("t6b", 32'hC040, 16, -1, 12'h0, 32'h0);
    do_wr("t6b", 32'hC040, 32'hD040, 16, 16);
    do_rd("t6c", 32'hC080, 8, -1, 12'h0, 32'h0);
    do_wr("t6c", 32'hC080, 32'hD080, 8, 8);
    wait_irq("t6", 5);
`endif
    reg_wr(EN, 32'd0);
    chk("t6_irq_clr", 32'(interrupt_dma), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
